pd_header_sequencer: RTL and testbench

Sequencer that owns the write port of the 80-byte header storage block (chunk_1 = bytes 0..63, chunk_2 = bytes 64..79) in the mining datapath. It accepts a header byte stream from the host-interface receiver and writes bytes 0..79 in order. It then launches the hasher and, on each unsuccessful hash, increments the 32-bit nonce and rewrites header bytes 76..79. This repeats until a solution is found or the nonce space is exhausted.

---
 rtl/pd_header_sequencer_if.sv | 23 ++
 rtl/pd_header_sequencer.sv | 110 +++++++++++
 tb/tb_pd_header_sequencer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pd_header_sequencer_if.sv
// Byte stream, header-storage write port and hasher handshake of the header sequencer.
// The sequencer side uses the master modport; the environment uses slave.
interface pd_header_sequencer_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       o_data_en;
  logic [7:0] o_data;
  logic [6:0] o_data_sel;
  logic       hash_start;
  logic       hash_done;
  logic       hash_found;

  modport master (
    input  in_valid, in_data, hash_done, hash_found,
    output in_ready, o_data_en, o_data, o_data_sel, hash_start
  );

  modport slave (
    output in_valid, in_data, hash_done, hash_found,
    input  in_ready, o_data_en, o_data, o_data_sel, hash_start
  );
endinterface

// File: rtl/pd_header_sequencer.sv
// Header sequencer: loads the 80-byte header into storage, launches the hasher and
// rewrites the nonce bytes after each unsuccessful hash until found or exhausted.
module pd_header_sequencer #(
  parameter int HEADER_BYTES = 80,
  parameter int NONCE_BASE   = 76
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_load,
  input  logic                    i_abort,
  pd_header_sequencer_if.master   bus,
  output logic                    o_busy,
  output logic                    o_found,
  output logic                    o_exhausted,
  output logic [31:0]             o_nonce
);

  typedef enum logic [2:0] {
    IDLE, LOAD, SETTLE, START, HASH, NONCE_WR, FOUND, EXHAUST
  } state_t;

  localparam logic [6:0] LAST_IDX = 7'(HEADER_BYTES - 1);
  localparam logic [6:0] NB_IDX   = 7'(NONCE_BASE);

  state_t     state;
  logic [6:0] count;
  logic [1:0] sub;
  logic [1:0] load_nsel;
  logic       in_nonce_window;

  function automatic logic [7:0] nonce_byte(input logic [31:0] n, input logic [1:0] b);
    return n[{b, 3'b000} +: 8];
  endfunction

  assign load_nsel       = 2'(count - NB_IDX);
  assign in_nonce_window = (count >= NB_IDX) && (count < NB_IDX + 7'd4);

  // in_ready is a pure state decode so upstream sees no path from in_valid
  assign bus.in_ready = (state == LOAD);
  assign o_busy       = (state == LOAD) || (state == SETTLE) || (state == START) ||
                        (state == HASH) || (state == NONCE_WR);
  assign o_found      = (state == FOUND);
  assign o_exhausted  = (state == EXHAUST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      count          <= '0;
      sub            <= '0;
      o_nonce        <= '0;
      bus.o_data_en  <= 1'b0;
      bus.o_data     <= '0;
      bus.o_data_sel <= '0;
      bus.hash_start <= 1'b0;
    end else begin
      bus.o_data_en  <= 1'b0;
      bus.hash_start <= 1'b0;
      if (i_abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE, FOUND, EXHAUST: begin
            if (i_load) begin
              state <= LOAD;
              count <= '0;
            end
          end
          LOAD: begin
            if (bus.in_valid) begin
              bus.o_data_en  <= 1'b1;
              bus.o_data_sel <= count;
              bus.o_data     <= bus.in_data;
              if (in_nonce_window) o_nonce[{load_nsel, 3'b000} +: 8] <= bus.in_data;
              count <= count + 7'd1;
              if (count == LAST_IDX) state <= SETTLE;
            end
          end
          SETTLE: state <= START;
          START: begin
            bus.hash_start <= 1'b1;
            state          <= HASH;
          end
          HASH: begin
            if (bus.hash_done) begin
              if (bus.hash_found) begin
                state <= FOUND;
              end else if (&o_nonce) begin
                state <= EXHAUST;
              end else begin
                o_nonce <= o_nonce + 32'd1;
                sub     <= '0;
                state   <= NONCE_WR;
              end
            end
          end
          NONCE_WR: begin
            // o_nonce already holds the incremented value here
            bus.o_data_en  <= 1'b1;
            bus.o_data_sel <= NB_IDX + 7'(sub);
            bus.o_data     <= nonce_byte(o_nonce, sub);
            sub            <= sub + 2'd1;
            if (sub == 2'd3) state <= SETTLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pd_header_sequencer.sv
// Randomized bench for pd_header_sequencer: an event-schedule reference model predicts
// every output per cycle; a few literal checks pin the model to hand-computed values.
module tb_pd_header_sequencer;

  logic        tb_clk = 1'b0;
  logic        rst;
  logic        i_load;
  logic        i_abort;
  logic        o_busy, o_found, o_exhausted;
  logic [31:0] o_nonce;

  pd_header_sequencer_if bus();

  pd_header_sequencer #(.HEADER_BYTES(80), .NONCE_BASE(76)) dut (
    .clk(tb_clk), .rst(rst), .i_load(i_load), .i_abort(i_abort), .bus(bus.master),
    .o_busy(o_busy), .o_found(o_found), .o_exhausted(o_exhausted), .o_nonce(o_nonce)
  );

  always #5 tb_clk = ~tb_clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: coarse job phases plus a per-edge schedule of port events
  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_FOUND = 3, P_EXH = 4;
  localparam int SZ = 8192;

  bit          s_en  [SZ];
  logic [6:0]  s_sel [SZ];
  logic [7:0]  s_dat [SZ];
  bit          s_hs  [SZ];

  int          phase = P_IDLE;
  int          cyc = 0;
  int          m_idx = 0;
  int          honor_at = 0;
  logic [31:0] m_nonce = '0;
  bit          m_started = 0;
  logic        exp_en, exp_hs, exp_rdy, exp_busy, exp_found, exp_exh;
  logic [6:0]  exp_sel = '0;
  logic [7:0]  exp_dat = '0;

  function automatic void clear_from(input int e);
    for (int j = 0; j < 16; j++) begin
      s_en[(e + j) % SZ] = 0;
      s_hs[(e + j) % SZ] = 0;
    end
  endfunction

  function automatic void sched(input int e, input int sel, input logic [7:0] d);
    s_en[e % SZ]  = 1;
    s_sel[e % SZ] = 7'(sel);
    s_dat[e % SZ] = d;
  endfunction

  always @(posedge tb_clk) begin
    int e;
    logic [31:0] nn;
    cyc++;
    e = cyc;
    if (rst) begin
      phase = P_IDLE; m_nonce = '0; exp_sel = '0; exp_dat = '0;
      clear_from(e);
    end else if (i_abort) begin
      phase = P_IDLE;
      clear_from(e);
    end else begin
      case (phase)
        P_IDLE, P_FOUND, P_EXH:
          if (i_load) begin phase = P_LOAD; m_idx = 0; end
        P_LOAD:
          if (bus.in_valid) begin
            sched(e, m_idx, bus.in_data);
            if (m_idx >= 76) m_nonce[8*(m_idx-76) +: 8] = bus.in_data;
            m_idx++;
            if (m_idx == 80) begin
              phase = P_RUN; s_hs[(e + 2) % SZ] = 1; honor_at = e + 3;
            end
          end
        P_RUN:
          if (bus.hash_done && e >= honor_at) begin
            if (bus.hash_found) phase = P_FOUND;
            else if (m_nonce == 32'hFFFF_FFFF) phase = P_EXH;
            else begin
              nn = m_nonce + 1;
              m_nonce = nn;
              for (int j = 0; j < 4; j++) sched(e + 1 + j, 76 + j, nn[8*j +: 8]);
              s_hs[(e + 6) % SZ] = 1;
              honor_at = e + 7;
            end
          end
        default: phase = P_IDLE;
      endcase
    end
    exp_en = s_en[e % SZ];
    exp_hs = s_hs[e % SZ];
    if (exp_en) begin exp_sel = s_sel[e % SZ]; exp_dat = s_dat[e % SZ]; end
    s_en[e % SZ] = 0;
    s_hs[e % SZ] = 0;
    exp_rdy   = (phase == P_LOAD);
    exp_busy  = (phase == P_LOAD) || (phase == P_RUN);
    exp_found = (phase == P_FOUND);
    exp_exh   = (phase == P_EXH);
    m_started = 1;
  end

  // Compare process plus a log of observed writes for the literal checks
  int         en_cnt = 0;
  logic [14:0] wlog[$];

  always @(negedge tb_clk) begin
    if (m_started) begin
      chk("in_ready",    32'(bus.in_ready),   32'(exp_rdy));
      chk("o_data_en",   32'(bus.o_data_en),  32'(exp_en));
      chk("o_data_sel",  32'(bus.o_data_sel), 32'(exp_sel));
      chk("o_data",      32'(bus.o_data),     32'(exp_dat));
      chk("hash_start",  32'(bus.hash_start), 32'(exp_hs));
      chk("o_busy",      32'(o_busy),         32'(exp_busy));
      chk("o_found",     32'(o_found),        32'(exp_found));
      chk("o_exhausted", 32'(o_exhausted),    32'(exp_exh));
      chk("o_nonce",     o_nonce,             m_nonce);
      if (bus.o_data_en === 1'b1) begin
        en_cnt++;
        wlog.push_back({bus.o_data_sel, bus.o_data});
      end
    end
  end

  logic [7:0] hdr [80];

  task automatic idle_inputs();
    i_load = 0; i_abort = 0; bus.in_valid = 0; bus.in_data = 8'($urandom);
    bus.hash_done = 0; bus.hash_found = 0;
  endtask

  task automatic load_job(input bit bubbles, input int abort_idx);
    int idx = 0;
    int guard = 0;
    bit v;
    i_load = 1;
    @(negedge tb_clk);
    i_load = 0;
    while (idx < 80 && guard < 400) begin
      if (abort_idx >= 0 && idx == abort_idx + 1) begin
        i_abort = 1; bus.in_valid = 0;
        @(negedge tb_clk);
        i_abort = 0;
        return;
      end
      v = !(bubbles && (guard % 3 == 2));
      bus.in_valid   = v;
      bus.in_data    = hdr[idx];
      bus.hash_done  = 1'($urandom);
      bus.hash_found = 1'($urandom);
      @(negedge tb_clk);
      if (v) idx++;
      guard++;
    end
    bus.in_valid = 0; bus.hash_done = 0; bus.hash_found = 0;
  endtask

  task automatic wait_hs();
    int t = 0;
    while (bus.hash_start !== 1'b1 && t < 40) begin
      bus.in_valid = 1'($urandom); bus.in_data = 8'($urandom);
      @(negedge tb_clk);
      t++;
    end
    bus.in_valid = 0;
    if (bus.hash_start !== 1'b1) chk("hash_start_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_done(input bit found, input int delay);
    repeat (delay) @(negedge tb_clk);
    bus.hash_done = 1; bus.hash_found = found;
    @(negedge tb_clk);
    bus.hash_done = 0; bus.hash_found = 0;
  endtask

  task automatic rand_hdr();
    for (int i = 0; i < 80; i++) hdr[i] = 8'($urandom);
    hdr[79] = 8'($urandom_range(0, 254));
  endtask

  initial begin
    int base;
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      i_load = 1'($urandom); i_abort = 1'($urandom);
      bus.in_valid = 1'($urandom); bus.in_data = 8'($urandom);
      bus.hash_done = 1'($urandom); bus.hash_found = 1'($urandom);
      @(negedge tb_clk);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_nonce", o_nonce, 32'd0);
    end
    rst = 0;
    idle_inputs();
    @(negedge tb_clk);

    // Full load with byte value = index
    for (int i = 0; i < 80; i++) hdr[i] = 8'(i);
    base = en_cnt;
    load_job(0, -1);
    wait_hs();
    chk("load_writes", 32'(en_cnt - base), 32'd80);
    chk("load_nonce", o_nonce, 32'h4F4E_4D4C);
    chk("load_busy", 32'(o_busy), 32'd1);

    // Retry, then find; i_load during HASH is ignored
    base = wlog.size();
    do_done(0, 0);
    wait_hs();
    chk("retry_cnt", 32'(wlog.size() - base), 32'd4);
    if (wlog.size() >= base + 4) begin
      chk("retry_w0", 32'(wlog[base + 0]), {17'd0, 7'd76, 8'h4D});
      chk("retry_w1", 32'(wlog[base + 1]), {17'd0, 7'd77, 8'h4D});
      chk("retry_w2", 32'(wlog[base + 2]), {17'd0, 7'd78, 8'h4E});
      chk("retry_w3", 32'(wlog[base + 3]), {17'd0, 7'd79, 8'h4F});
    end
    i_load = 1;
    @(negedge tb_clk);
    i_load = 0;
    do_done(1, 1);
    chk("found_flag", 32'(o_found), 32'd1);
    chk("found_busy", 32'(o_busy), 32'd0);
    chk("found_nonce", o_nonce, 32'h4F4E_4D4D);
    do_done(0, 2);
    chk("found_hold", o_nonce, 32'h4F4E_4D4D);

    // Bubbled load from FOUND, random retries
    rand_hdr();
    load_job(1, -1);
    wait_hs();
    for (int r = 0; r < 3; r++) begin
      do_done(0, $urandom_range(0, 3));
      wait_hs();
    end
    do_done(1, $urandom_range(0, 3));

    // Exhaustion
    rand_hdr();
    for (int i = 76; i < 80; i++) hdr[i] = 8'hFF;
    load_job(0, -1);
    wait_hs();
    base = en_cnt;
    do_done(0, 1);
    repeat (8) @(negedge tb_clk);
    chk("exh_flag", 32'(o_exhausted), 32'd1);
    chk("exh_no_write", 32'(en_cnt - base), 32'd0);
    chk("exh_nonce", o_nonce, 32'hFFFF_FFFF);
    do_done(1, 0);

    // Abort mid-load, then restart; abort with i_load in HASH
    rand_hdr();
    load_job(0, 40);
    chk("abort_ready", 32'(bus.in_ready), 32'd0);
    chk("abort_busy", 32'(o_busy), 32'd0);
    base = wlog.size();
    rand_hdr();
    load_job(0, -1);
    if (wlog.size() > base) chk("restart_sel0", 32'(wlog[base][14:8]), 32'd0);
    wait_hs();
    i_abort = 1; i_load = 1;
    @(negedge tb_clk);
    i_abort = 0; i_load = 0;
    chk("abort_hash_busy", 32'(o_busy), 32'd0);

    // Random jobs
    for (int j = 0; j < 4; j++) begin
      rand_hdr();
      load_job(1'($urandom), -1);
      wait_hs();
      for (int r = 0; r < int'($urandom_range(0, 2)); r++) begin
        do_done(0, $urandom_range(0, 2));
        wait_hs();
      end
      do_done(1, $urandom_range(0, 2));
      repeat (2) @(negedge tb_clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
